cpu_prog_feeder: RTL
====================

# cpu_prog_feeder

Upstream stage for the lab 6 `cpu` datapath/controller. It holds a small instruction store and feeds it into the cpu one word at a time, driving the cpu's `in`, `load` and `s` inputs from an FSM. It uses the cpu's `w` (waiting) output as the completion handshake. A watchdog flags a cpu that never accepts or never completes an instruction.

## Interface
- `ADDR_W`, default 4: instruction store address width; depth is 2^ADDR_W words of 16 bits.
- `TIMEOUT`, default 63: maximum cycles spent waiting on `cpu_w` in any one wait state before error.
- `clk`  in  1: single clock; all state updates on rising edge.
- `reset`  in  1: synchronous, active-high.
- `start`  in  1: begin running the stored program from address 0; sampled only in IDLE.
- `prog_len`  in  ADDR_W+1: number of instructions to run, 0..2^ADDR_W; sampled when start is accepted.
- `prog_we`  in  1: store write enable.
- `prog_addr`  in  ADDR_W: store write address.
- `prog_data`  in  16: store write data.
- `cpu_w`  in  1: cpu `w` output, where 1 means the cpu is in its wait state.
- `cpu_in`  out  16: to cpu `in`.
- `cpu_load`  out  1: to cpu `load`.
- `cpu_s`  out  1: to cpu `s`.
- `busy`  out  1: high in LOAD, START and EXEC.
- `done`  out  1: one-cycle pulse when the program completes.
- `err`  out  1: sticky watchdog error.
- `pc`  out  ADDR_W: index of the current instruction.
- `exec_count`  out  ADDR_W+1: instructions completed since the last start.

## Operation
- **States:** IDLE, LOAD, START, EXEC, DONE, ERR. State, `pc`, `exec_count`, the `cpu_in` register and the watchdog counter are all registers.
- **Outputs:** every output is a function of registered state only. No input-to-output combinational path.
- **IDLE:** all control outputs are 0.
  - `start`=1 with `prog_len`=0: go to DONE.
  - `start`=1 with `prog_len`>0 and `cpu_w`=1: latch `prog_len`, clear `pc`, `exec_count` and `err`, load `cpu_in`<=mem[0], go to LOAD.
  - `start` while `cpu_w`=0 is ignored.
- **LOAD:** `cpu_load`=1 for exactly one cycle, then go to START.
- **START:** `cpu_s`=1 and held until `cpu_w` is sampled 0, then go to EXEC.
- **EXEC:** `cpu_s`=0. Wait for `cpu_w` to be sampled 1, then increment `exec_count`.
  - If `pc`==len-1: go to DONE.
  - Otherwise: `pc`<=`pc`+1, `cpu_in`<=mem[`pc`+1], go to LOAD.
- **DONE:** `done`=1 for one cycle, then go to IDLE.
- **Watchdog:** the counter clears on entry to START and on entry to EXEC, and increments each cycle spent in those states. When it reaches `TIMEOUT` while still waiting, go to ERR.
- **ERR:** `err`=1, all cpu controls 0. Leaves only on reset, or on `start` (same acceptance rules as IDLE; `err` clears on acceptance).
- **Store writes:** `prog_we` writes mem[`prog_addr`] in IDLE, DONE and ERR. Writes while `busy` are ignored. The store is not reset.
- **`cpu_in` between instructions:** holds the current instruction from LOAD through EXEC and is unchanged after completion.
- **Width rules:**
  - `pc` never wraps: a program of length 2^ADDR_W ends at `pc`=2^ADDR_W-1.
  - `prog_len` values above 2^ADDR_W are clamped to 2^ADDR_W.

## Timing
- **Reset:** state=IDLE, `pc`=0, `exec_count`=0, `cpu_in`=0, and `cpu_load`, `cpu_s`, `busy`, `done`, `err` all 0, from the first edge with `reset`=1.
- **Reset priority:** reset mid-operation overrides everything, including a pending `done` or `err`.
- **Start latency:** `start` is sampled at edge k; `cpu_load`=1 during cycle k+1 and `cpu_s`=1 from cycle k+2.
- **Per instruction:** cost is 1 (LOAD) + START cycles (at least 1) + EXEC cycles (at least 1).
- **Completion:** `done` rises one cycle after the edge that samples the final `cpu_w`=1.
- **Back-to-back instructions:** the next `cpu_load` occurs the cycle after `cpu_w` is observed 1. There are no idle cycles between instructions.
- **Simultaneous events:** `prog_we` together with `start` in IDLE performs the write first, so mem[0] reflects the new data if `prog_addr`=0.

## Test plan
- **Reset:** assert `reset` 2 cycles mid-EXEC -> the next cycle shows all outputs 0, state IDLE and `pc`=0; a subsequent start runs from address 0.
- **Three-word program:** bench cpu model drops `w` 1 cycle after `s` and raises it 3 cycles later; program 0xD007, 0xC068, 0xD102 with `prog_len`=3 -> three `cpu_load` pulses carrying those words in order, one `done` pulse, `exec_count`=3, `err`=0.
- **Empty program:** `prog_len`=0 with `start` -> `done` pulse the next cycle, no `cpu_load` or `cpu_s`.
- **Stuck cpu:** model holds `w`=1 forever -> `cpu_s` stays high for 63 cycles, then `err`=1 and `cpu_s`=0; a new start clears `err`.
- **Write while busy:** `prog_we` to address 1 during execution is ignored; the same write in DONE takes effect on the next run.
- **Integration with the real `cpu`:** program 0xD007, 0xC068, 0xD102, 0xA148 -> after `done`, the cpu `out` reads 16 and `Z`=0.

Source files
------------

// File: rtl/cpu_prog_feeder.sv
// cpu_prog_feeder: feeds a small instruction store into the lab 6 cpu over its load/s/w handshake
module cpu_prog_feeder #(
    parameter int ADDR_W  = 4,
    parameter int TIMEOUT = 63
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W:0]   prog_len,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [15:0]       prog_data,
    input  logic              cpu_w,
    output logic [15:0]       cpu_in,
    output logic              cpu_load,
    output logic              cpu_s,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W:0]   exec_count
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int WD_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, LOAD, START, EXEC, DONE, ERR} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d, pc_nx;
    logic [ADDR_W:0]   cnt_q, cnt_d, len_q, len_d, len_clamp;
    logic [15:0]       in_q, in_d, mem0;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic [15:0]       mem [DEPTH];
    logic              wr_ok, wd_expired, last;

    assign wr_ok      = prog_we && (state_q == IDLE || state_q == DONE || state_q == ERR);
    assign len_clamp  = (prog_len > (ADDR_W+1)'(DEPTH)) ? (ADDR_W+1)'(DEPTH) : prog_len;
    // a write to address 0 in the same cycle as start must be seen by the first fetch
    assign mem0       = (wr_ok && prog_addr == '0) ? prog_data : mem[0];
    assign wd_expired = wd_q == WD_W'(TIMEOUT - 1);
    assign last       = {1'b0, pc_q} == len_q - 1'b1;
    assign pc_nx      = pc_q + 1'b1;

    // instruction store, writable only while no program is running
    always_ff @(posedge clk) begin
        if (wr_ok) mem[prog_addr] <= prog_data;
    end

    // state and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            in_q    <= '0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            in_q    <= in_d;
            wd_q    <= wd_d;
        end
    end

    // next-state: sequencing, instruction fetch and watchdog
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        in_d    = in_q;
        wd_d    = wd_q;
        case (state_q)
            IDLE, ERR: begin
                if (start && len_clamp == '0) begin
                    state_d = DONE;
                end else if (start && cpu_w) begin
                    len_d   = len_clamp;
                    pc_d    = '0;
                    cnt_d   = '0;
                    in_d    = mem0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                wd_d    = '0;
                state_d = START;
            end
            START: begin
                if (!cpu_w) begin
                    wd_d    = '0;
                    state_d = EXEC;
                end else if (wd_expired) begin
                    state_d = ERR;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            EXEC: begin
                if (cpu_w) begin
                    cnt_d = cnt_q + 1'b1;
                    if (last) begin
                        state_d = DONE;
                    end else begin
                        pc_d    = pc_nx;
                        in_d    = mem[pc_nx];
                        state_d = LOAD;
                    end
                end else if (wd_expired) begin
                    state_d = ERR;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // outputs decoded from registered state only
    always_comb begin
        cpu_load   = state_q == LOAD;
        cpu_s      = state_q == START;
        busy       = state_q == LOAD || state_q == START || state_q == EXEC;
        done       = state_q == DONE;
        err        = state_q == ERR;
        pc         = pc_q;
        exec_count = cnt_q;
        cpu_in     = in_q;
    end
endmodule
